fetch_align_ctrl: RTL and testbench
===================================

// Module: fetch_align_ctrl
// PURPOSE
//  Fetch sequencer and halfword realigner in front of the RVC expander. Issues
//  word-aligned fetches, buffers returned halfwords and assembles 16/32-bit
//  instructions, including 32-bit ones that straddle a word boundary.
//  Handles PC redirects and presents one instruction per valid/ready handshake,
//  with the PC and a compressed flag, to the expander and decode stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch PC after reset; must be halfword-aligned
//  HW_DEPTH   4              halfword buffer entries; power of 2, >= 4
// PORTS
//  clk               in   1   clock, rising edge
//  rst_n             in   1   asynchronous active-low reset
//  redirect_valid    in   1   flush and restart fetch at redirect_pc (1 cycle)
//  redirect_pc       in   32  new PC, halfword-aligned
//  fetch_req_valid   out  1   fetch request
//  fetch_req_ready   in   1   memory accepts request
//  fetch_req_addr    out  32  word address, [1:0] = 0
//  fetch_rsp_valid   in   1   read data valid; arrives >= 1 cycle after accept
//  fetch_rsp_data    in   32  read data; [15:0] = lower halfword
//  instr_valid       out  1   instr_raw holds a complete instruction
//  instr_ready       in   1   consumer takes instruction
//  instr_raw         out  32  {16'b0,hw} if compressed, else {hw1,hw0}
//  instr_compressed  out  1   1 = instr_raw[15:0] is an RVC instruction
//  instr_pc          out  32  PC of instr_raw
// BEHAVIOUR
//  Reset: fetch_req_valid=0, instr_valid=0, instr_raw=0, instr_compressed=0,
//   instr_pc=RESET_PC, buffer empty, FSM=F_IDLE, fetch PC=RESET_PC.
//   fetch_req_valid is first asserted in the first cycle after rst_n rises.
//  Fetch FSM (max 1 outstanding):
//   F_IDLE: fetch_req_valid=free>=2 && !redirect_valid; accepted -> F_PEND.
//   F_PEND: rsp -> push 2 halfwords, F_IDLE; redirect&&!rsp -> F_DROP;
//           redirect&&rsp -> data discarded, F_IDLE.
//   F_DROP: rsp -> discard, F_IDLE. No requests in F_PEND or F_DROP.
//  Fetch addr = {fetch_pc[31:2],2'b00}; +4 per accepted request.
//  Misaligned start (pc[1]=1): skip_lo flag drops hw0 of next kept response.
//  Buffer: circular, HW_DEPTH entries, pointers wrap mod HW_DEPTH. Write
//   happens the cycle after rsp; instr_valid is earliest 1 cycle after rsp.
//  Assembly at head: head[1:0]!=2'b11 and count>=1 -> compressed, pop 1,
//   pc+=2; head[1:0]==2'b11 and count>=2 -> 32-bit, pop 2, pc+=4; else
//   instr_valid=0 (straddling word waits for next response).
//  Outputs are combinational from head; stable while valid && !ready.
//  Push and pop in one cycle allowed; count updates by net amount.
//  Full buffer (free<2): no new request; resumes once pops free 2 entries.
//  Redirect has priority: buffer flushed, instr_valid forced 0 that cycle
//   (a same-cycle handshake is void), fetch_pc=redirect_pc,
//   skip_lo=redirect_pc[1], instr_pc=redirect_pc next cycle.
//  Reset mid-operation: immediate return to reset state; outstanding
//   response discarded after reset is released.
// CONFIGURATION
//  FETCH_ALIGN_RVC_EN defined: full 16/32-bit realignment as above.
//  Undefined: all instructions 32-bit, one per response, no buffer
//   straddling; instr_compressed tied 0; redirect_pc[1] ignored (treated 0);
//   instr_raw = response word.
// TESTING
//  Reset release, RESET_PC=0 -> next cycle fetch_req_valid=1, addr 0x0.
//  Rsp 0x0505_4501 @0x0 -> instr 0x4501 pc 0x0 c=1, then 0x0505 pc 0x2 c=1.
//  Rsp 0x0513_4501 then 0x0000_0093 -> 0x4501 pc0 c=1; 0x0093_0513 pc2 c=0.
//  Redirect 0x102, rsp @0x100 = 0x4585_FFFF -> hw0 dropped; 0x4585 pc 0x102.
//  Redirect while F_PEND -> that rsp discarded; next req addr = redirect addr.
//  instr_ready=0 with all-RVC rsps -> 4 halfwords buffered, no fetch_req_valid.
//   Raise ready -> 4 pops, fetch resumes after free>=2.

Source files
------------

// File: rtl/fetch_align_ctrl.sv
// Word-fetch sequencer + halfword realigner feeding RVC expander/decode; FETCH_ALIGN_RVC_EN enables 16/32-bit realignment.
// Latency: instr_valid earliest one cycle after fetch_rsp_valid; fetch_req_valid first asserts one cycle after reset release.
// Backpressure: instr_ready low holds the head stable; fetch requests stall while fewer than 2 buffer entries are free.
module fetch_align_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          HW_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_req_valid,
    input  logic        fetch_req_ready,
    output logic [31:0] fetch_req_addr,
    input  logic        fetch_rsp_valid,
    input  logic [31:0] fetch_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_raw,
    output logic        instr_compressed,
    output logic [31:0] instr_pc
);

    localparam int             PW      = $clog2(HW_DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(HW_DEPTH);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);
    localparam logic [CW-1:0]  TWO_C   = CW'(2);

    typedef enum logic [1:0] {
        F_IDLE,
        F_PEND,
        F_DROP
    } fstate_t;

    fstate_t        state_q, state_d;
    logic           run_q, run_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    pc_q, pc_d;
    logic           skip_lo_q, skip_lo_d;
    logic [15:0]    buf_q [HW_DEPTH];
    logic [15:0]    buf_d [HW_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic [15:0]    hd0, hd1;
    logic           head_c;
    logic           head_avail;
    logic           pop;
    logic [CW-1:0]  pop_n;
    logic [CW-1:0]  push_n;
    logic [CW-1:0]  free_n;
    logic           req_fire;
    logic           rsp_keep;
    logic [31:0]    redir_pc;

    // Head decode: classify the oldest halfword and present the assembled instruction.
    always_comb begin
        hd0        = buf_q[rd_ptr_q];
        hd1        = buf_q[rd_ptr_q + PW'(1)];
`ifdef FETCH_ALIGN_RVC_EN
        head_c     = (hd0[1:0] != 2'b11);
`else
        head_c     = 1'b0;
`endif
        head_avail = head_c ? (count_q >= ONE_C) : (count_q >= TWO_C);
        // Redirect voids any handshake in the same cycle.
        instr_valid      = head_avail && !redirect_valid;
        instr_compressed = head_avail && head_c;
        instr_raw        = 32'h0;
        if (head_avail) begin
            instr_raw = head_c ? {16'h0000, hd0} : {hd1, hd0};
        end
        instr_pc = pc_q;
        pop      = instr_valid && instr_ready;
        pop_n    = '0;
        if (pop) begin
            pop_n = head_c ? ONE_C : TWO_C;
        end
    end

    // Fetch FSM, buffer write/pointer update and redirect flush.
    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        skip_lo_d  = skip_lo_q;
        buf_d      = buf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push_n     = '0;

`ifdef FETCH_ALIGN_RVC_EN
        redir_pc = redirect_pc & 32'hFFFF_FFFE;
`else
        redir_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

        free_n          = DEPTH_C - count_q;
        fetch_req_addr  = fetch_pc_q & 32'hFFFF_FFFC;
        fetch_req_valid = run_q && (state_q == F_IDLE) && (free_n >= TWO_C) && !redirect_valid;
        req_fire        = fetch_req_valid && fetch_req_ready;
        // Responses only count while a request is outstanding; stray ones after reset fall on F_IDLE.
        rsp_keep        = (state_q == F_PEND) && fetch_rsp_valid && !redirect_valid;

        case (state_q)
            F_IDLE: begin
                if (req_fire) begin
                    state_d    = F_PEND;
                    fetch_pc_d = fetch_req_addr + 32'd4;
                end
            end
            F_PEND: begin
                if (fetch_rsp_valid) begin
                    state_d = F_IDLE;
                end else if (redirect_valid) begin
                    state_d = F_DROP;
                end
            end
            F_DROP: begin
                if (fetch_rsp_valid) begin
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase

        if (rsp_keep) begin
            skip_lo_d = 1'b0;
            if (skip_lo_q) begin
                // Misaligned entry point: only the upper halfword belongs to the stream.
                buf_d[wr_ptr_q] = fetch_rsp_data[31:16];
                wr_ptr_d        = wr_ptr_q + PW'(1);
                push_n          = ONE_C;
            end else begin
                buf_d[wr_ptr_q]          = fetch_rsp_data[15:0];
                buf_d[wr_ptr_q + PW'(1)] = fetch_rsp_data[31:16];
                wr_ptr_d                 = wr_ptr_q + PW'(2);
                push_n                   = TWO_C;
            end
        end

        rd_ptr_d = rd_ptr_q + pop_n[PW-1:0];
        count_d  = count_q + push_n - pop_n;
        if (pop) begin
            pc_d = pc_q + (head_c ? 32'd2 : 32'd4);
        end

        if (redirect_valid) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            pc_d       = redir_pc;
            fetch_pc_d = redir_pc;
            skip_lo_d  = redir_pc[1];
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= F_IDLE;
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            skip_lo_q  <= RESET_PC[1];
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < HW_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            skip_lo_q  <= skip_lo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl; expectations follow the FETCH_ALIGN_RVC_EN build setting.
// Inputs driven and outputs sampled around the falling edge.
// Responses arrive one cycle after each accepted request.
module tb_fetch_align_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [31:0] fetch_req_addr;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_raw;
    logic        instr_compressed;
    logic [31:0] instr_pc;

    int total  = 0;
    int passed = 0;

    fetch_align_ctrl #(
        .RESET_PC (32'h0000_0000),
        .HW_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_req_addr   (fetch_req_addr),
        .fetch_rsp_valid  (fetch_rsp_valid),
        .fetch_rsp_data   (fetch_rsp_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_raw        (instr_raw),
        .instr_compressed (instr_compressed),
        .instr_pc         (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        while (fetch_req_valid !== 1'b1 && n < 64) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_req_vld"}, 32'(fetch_req_valid), 32'd1);
        chk({tag, "_req_addr"}, fetch_req_addr, addr);
        fetch_req_ready = 1'b1;
        @(negedge clk);
        fetch_req_ready = 1'b0;
        fetch_rsp_valid = 1'b1;
        fetch_rsp_data  = data;
        @(negedge clk);
        fetch_rsp_valid = 1'b0;
        #1;
    endtask

    task automatic pop_instr(input string tag, input logic [31:0] raw, input logic [31:0] pc, input logic c);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 64) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_vld"}, 32'(instr_valid), 32'd1);
        chk({tag, "_raw"}, instr_raw, raw);
        chk({tag, "_pc"}, instr_pc, pc);
        chk({tag, "_c"}, 32'(instr_compressed), 32'(c));
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        fetch_req_ready = 1'b0;
        fetch_rsp_valid = 1'b0;
        fetch_rsp_data  = 32'h0;
        instr_ready     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_vld", 32'(fetch_req_valid), 32'd0);
        chk("rst_instr_vld", 32'(instr_valid), 32'd0);
        chk("rst_raw", instr_raw, 32'h0);
        chk("rst_c", 32'(instr_compressed), 32'd0);
        chk("rst_pc", instr_pc, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_vld0", 32'(fetch_req_valid), 32'd0);
        @(negedge clk); #1;
        chk("rel_req_vld1", 32'(fetch_req_valid), 32'd1);
        chk("rel_req_addr", fetch_req_addr, 32'h0);

        // Two compressed halfwords in one word
        do_fetch("a", 32'h0, 32'h0505_4501);
`ifdef FETCH_ALIGN_RVC_EN
        pop_instr("a0", 32'h0000_4501, 32'h0, 1'b1);
        pop_instr("a1", 32'h0000_0505, 32'h2, 1'b1);
`else
        pop_instr("a0", 32'h0505_4501, 32'h0, 1'b0);
`endif
        chk("a_empty", 32'(instr_valid), 32'd0);

        // 32-bit instruction straddling a word boundary
        do_fetch("b", 32'h4, 32'h0513_4501);
`ifdef FETCH_ALIGN_RVC_EN
        pop_instr("b0", 32'h0000_4501, 32'h4, 1'b1);
        chk("b_straddle_wait", 32'(instr_valid), 32'd0);
        do_fetch("b2", 32'h8, 32'h0000_0093);
        pop_instr("b1", 32'h0093_0513, 32'h6, 1'b0);
        pop_instr("b2", 32'h0000_0000, 32'hA, 1'b1);
`else
        pop_instr("b0", 32'h0513_4501, 32'h4, 1'b0);
        chk("b_empty", 32'(instr_valid), 32'd0);
        do_fetch("b2", 32'h8, 32'h0000_0093);
        pop_instr("b1", 32'h0000_0093, 32'h8, 1'b0);
`endif

        // Redirect to a misaligned PC
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        #1;
        chk("c_redir_req_vld", 32'(fetch_req_valid), 32'd0);
        chk("c_redir_instr_vld", 32'(instr_valid), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_ALIGN_RVC_EN
        chk("c_pc", instr_pc, 32'h102);
        do_fetch("c", 32'h100, 32'h4585_FFFF);
        pop_instr("c0", 32'h0000_4585, 32'h102, 1'b1);
`else
        chk("c_pc", instr_pc, 32'h100);
        do_fetch("c", 32'h100, 32'h4585_FFFF);
        pop_instr("c0", 32'h4585_FFFF, 32'h100, 1'b0);
`endif

        // Redirect while a response is outstanding
        do_fetch("d_pre_chk", 32'h104, 32'h0);
        // do_fetch above already sent a response; issue one more request then redirect before its response
        while (fetch_req_valid !== 1'b1 && total < 100000) begin
            @(negedge clk); #1;
        end
        // discard the pre-check instruction(s) via redirect below
        chk("d_req_addr", fetch_req_addr, 32'h108);
        fetch_req_ready = 1'b1;
        @(negedge clk);
        fetch_req_ready = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h200;
        @(negedge clk);
        redirect_valid  = 1'b0;
        fetch_rsp_valid = 1'b1;
        fetch_rsp_data  = 32'h1111_2222;
        @(negedge clk);
        fetch_rsp_valid = 1'b0;
        #1;
        chk("d_dropped", 32'(instr_valid), 32'd0);
        chk("d_pc", instr_pc, 32'h200);
        do_fetch("d", 32'h200, 32'h4501_4502);
`ifdef FETCH_ALIGN_RVC_EN
        pop_instr("d0", 32'h0000_4502, 32'h200, 1'b1);
        pop_instr("d1", 32'h0000_4501, 32'h202, 1'b1);
`else
        pop_instr("d0", 32'h4501_4502, 32'h200, 1'b0);
`endif

        // Full buffer stalls fetch until two entries are free
        do_fetch("e1", 32'h204, 32'h4505_4509);
        do_fetch("e2", 32'h208, 32'h450D_4511);
        repeat (2) @(negedge clk);
        #1;
        chk("e_full_no_req", 32'(fetch_req_valid), 32'd0);
`ifdef FETCH_ALIGN_RVC_EN
        chk("e_stable_raw", instr_raw, 32'h0000_4509);
        pop_instr("e0", 32'h0000_4509, 32'h204, 1'b1);
        chk("e_free1_no_req", 32'(fetch_req_valid), 32'd0);
        pop_instr("e1", 32'h0000_4505, 32'h206, 1'b1);
        chk("e_resume_req", 32'(fetch_req_valid), 32'd1);
        chk("e_resume_addr", fetch_req_addr, 32'h20C);
        pop_instr("e2", 32'h0000_4511, 32'h208, 1'b1);
        pop_instr("e3", 32'h0000_450D, 32'h20A, 1'b1);
`else
        chk("e_stable_raw", instr_raw, 32'h4505_4509);
        pop_instr("e0", 32'h4505_4509, 32'h204, 1'b0);
        chk("e_resume_req", 32'(fetch_req_valid), 32'd1);
        chk("e_resume_addr", fetch_req_addr, 32'h20C);
        pop_instr("e1", 32'h450D_4511, 32'h208, 1'b0);
`endif

        // Reset while a request is outstanding; late response ignored
        fetch_req_ready = 1'b1;
        @(negedge clk);
        fetch_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("f_rst_req_vld", 32'(fetch_req_valid), 32'd0);
        chk("f_rst_pc", instr_pc, 32'h0);
        chk("f_rst_instr_vld", 32'(instr_valid), 32'd0);
        @(negedge clk);
        rst_n           = 1'b1;
        fetch_rsp_valid = 1'b1;
        fetch_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        fetch_rsp_valid = 1'b0;
        #1;
        chk("f_stray_ignored", 32'(instr_valid), 32'd0);
        do_fetch("f", 32'h0, 32'h0000_4501);
`ifdef FETCH_ALIGN_RVC_EN
        pop_instr("f0", 32'h0000_4501, 32'h0, 1'b1);
`else
        pop_instr("f0", 32'h0000_4501, 32'h0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
